fifo_read_controller: RTL and testbench

Read-side controller for the asynchronous FIFO. It runs in the read clock domain and owns the read pointer and the empty flag. It addresses the dual-port memory buffer through its combinational read port and presents a first-word-fall-through (FWFT) valid/ready output stage. It publishes a Gray-coded read pointer for the write-domain synchronizer and consumes a write pointer already synchronized into read_clock.

---
 rtl/fifo_read_controller_if.sv | 26 ++
 rtl/fifo_read_controller.sv | 99 +++++++++
 tb/tb_fifo_read_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_controller_if.sv
// Purpose: FWFT output-stage handshake between the FIFO read controller and its consumer.
// Signals:
//   out_data  - registered output word (controller -> consumer)
//   out_valid - out_data holds a valid word (controller -> consumer)
//   out_ready - consumer accepts out_data this cycle (consumer -> controller)
interface fifo_read_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // Controller side drives the word and its valid flag.
  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Consumer side drives the ready flag.
  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fifo_read_controller.sv
// Purpose: read-clock-domain controller of an asynchronous FIFO. Owns the binary/Gray
// read pointer and the empty flag, reads the memory through its combinational read port
// and presents a first-word-fall-through valid/ready output stage.
// Ports:
//   read_clock, read_reset - clock and synchronous active-high reset
//   sync_write_ptr         - Gray write pointer already synchronized into read_clock
//   read_data / read_addr  - combinational memory read port
//   read_ptr               - registered Gray read pointer for the write-domain synchronizer
//   read_empty             - registered; memory holds no unread entry
//   read_count             - registered number of entries in memory not yet popped
//   out_if                 - FWFT output stage (out_data, out_valid, out_ready)
module fifo_read_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    read_clock,
  input  logic                    read_reset,
  input  logic [ADDR_WIDTH:0]     sync_write_ptr,
  input  logic [DATA_WIDTH-1:0]   read_data,
  output logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [ADDR_WIDTH:0]     read_ptr,
  output logic                    read_empty,
  output logic [ADDR_WIDTH:0]     read_count,
  fifo_read_controller_if.master  out_if
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         read_bin_q, read_bin_d;
  logic [PW-1:0]         read_ptr_q, read_ptr_d;
  logic                  read_empty_q, read_empty_d;
  logic [PW-1:0]         read_count_q, read_count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  pop_c;
  logic [PW-1:0]         bin_next_c;
  logic [PW-1:0]         gray_next_c;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Next-state logic: pop moves one word from memory into the output stage.
  always_comb begin
    pop_c        = !read_empty_q && (!out_valid_q || out_if.out_ready);
    bin_next_c   = read_bin_q + PW'(pop_c);
    gray_next_c  = bin_next_c ^ (bin_next_c >> 1);

    read_bin_d   = bin_next_c;
    read_ptr_d   = gray_next_c;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;

    if (pop_c) begin
      out_data_d  = read_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Compare against the post-pop pointer so the last pop raises empty on the same edge.
    read_empty_d = (gray_next_c == sync_write_ptr);
    read_count_d = gray2bin(sync_write_ptr) - bin_next_c;
  end

  // State registers with synchronous reset.
  always_ff @(posedge read_clock) begin
    if (read_reset) begin
      read_bin_q   <= '0;
      read_ptr_q   <= '0;
      read_empty_q <= 1'b1;
      read_count_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      read_bin_q   <= read_bin_d;
      read_ptr_q   <= read_ptr_d;
      read_empty_q <= read_empty_d;
      read_count_q <= read_count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign read_addr        = read_bin_q[ADDR_WIDTH-1:0];
  assign read_ptr         = read_ptr_q;
  assign read_empty       = read_empty_q;
  assign read_count       = read_count_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_read_controller.sv
// Testbench for fifo_read_controller: a behavioural memory plus write-pointer model feeds
// the DUT, expected words are queued as they are written, and a monitor checks every
// accepted beat, stalled-word stability and single-bit Gray pointer steps.
module tb_fifo_read_controller;

  logic       read_clock;
  logic       read_reset;
  logic [4:0] sync_write_ptr;
  logic [7:0] read_data;
  logic [3:0] read_addr;
  logic [4:0] read_ptr;
  logic       read_empty;
  logic [4:0] read_count;

  logic [7:0] mem [16];
  logic [4:0] wr_bin;
  logic [7:0] exp_q [$];

  int  n_cmp = 0;
  int  n_fail = 0;
  int  n_acc = 0;
  bit  gray_en = 1'b0;

  fifo_read_controller_if #(.DATA_WIDTH(8)) out_if ();

  fifo_read_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .read_clock     (read_clock),
    .read_reset     (read_reset),
    .sync_write_ptr (sync_write_ptr),
    .read_data      (read_data),
    .read_addr      (read_addr),
    .read_ptr       (read_ptr),
    .read_empty     (read_empty),
    .read_count     (read_count),
    .out_if         (out_if)
  );

  assign read_data = mem[read_addr];

  initial read_clock = 1'b0;
  always #5 read_clock = ~read_clock;

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge read_clock);
    #1;
  endtask

  // Write-side model: store a word, advance the write pointer, queue the expectation.
  task automatic push_word(input logic [7:0] v);
    mem[wr_bin[3:0]] = v;
    exp_q.push_back(v);
    wr_bin = wr_bin + 5'd1;
    sync_write_ptr = bin2gray(wr_bin);
  endtask

  task automatic do_reset();
    read_reset = 1'b1;
    wr_bin = '0;
    sync_write_ptr = '0;
    exp_q.delete();
    step();
    read_reset = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int limit, input string name);
    int  n;
    bit  done;
    n = 0;
    done = (exp_q.size() == 0) && !out_if.out_valid && read_empty;
    while (!done && n < limit) begin
      if (toggle) out_if.out_ready = ~out_if.out_ready;
      step();
      n++;
      done = (exp_q.size() == 0) && !out_if.out_valid && read_empty;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Monitor: checks accepted beats against the scoreboard, stall stability, Gray steps.
  initial begin
    bit         stall_prev;
    logic [7:0] stall_data;
    logic [4:0] prev_ptr;
    logic [7:0] expv;
    stall_prev = 1'b0;
    stall_data = '0;
    prev_ptr   = '0;
    forever begin
      @(negedge read_clock);
      if (read_reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 32'(out_if.out_valid), 32'd1);
          check("stall_data", 32'(out_if.out_data), 32'(stall_data));
        end
        if (out_if.out_valid && out_if.out_ready) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat (t=%0t)",
                     out_if.out_data, $time);
          end else begin
            expv = exp_q.pop_front();
            check("beat_data", 32'(out_if.out_data), 32'(expv));
          end
        end
        stall_prev = out_if.out_valid && !out_if.out_ready;
        stall_data = out_if.out_data;
        if (gray_en) begin
          check("gray_step", 32'($countones(read_ptr ^ prev_ptr) <= 1), 32'd1);
        end
      end
      prev_ptr = read_ptr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    read_reset       = 1'b1;
    wr_bin           = '0;
    sync_write_ptr   = '0;
    out_if.out_ready = 1'b0;

    // 1. Reset held two cycles.
    step();
    step();
    @(negedge read_clock);
    check("rst_empty", 32'(read_empty), 32'd1);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_ptr", 32'(read_ptr), 32'd0);
    check("rst_count", 32'(read_count), 32'd0);
    check("rst_data", 32'(out_if.out_data), 32'd0);
    step();
    read_reset = 1'b0;

    // 2. Single word with the consumer stalled, then one accept.
    push_word(8'hA5);
    step();
    @(negedge read_clock);
    check("t2_empty_c", 32'(read_empty), 32'd0);
    check("t2_count_c", 32'(read_count), 32'd1);
    check("t2_valid_c", 32'(out_if.out_valid), 32'd0);
    step();
    @(negedge read_clock);
    check("t2_valid", 32'(out_if.out_valid), 32'd1);
    check("t2_data", 32'(out_if.out_data), 32'hA5);
    check("t2_ptr", 32'(read_ptr), 32'b00001);
    check("t2_empty", 32'(read_empty), 32'd1);
    check("t2_count", 32'(read_count), 32'd0);
    repeat (3) step();
    out_if.out_ready = 1'b1;
    step();
    out_if.out_ready = 1'b0;
    @(negedge read_clock);
    check("t2_consumed", 32'(out_if.out_valid), 32'd0);
    check("t2_acc", 32'(n_acc), 32'd1);

    // 3. Full 16-entry burst from a fresh reset.
    do_reset();
    out_if.out_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    step();
    @(negedge read_clock);
    check("t3_count_full", 32'(read_count), 32'd16);
    check("t3_empty", 32'(read_empty), 32'd0);
    drain(1'b0, 40, "t3_drain");
    @(negedge read_clock);
    check("t3_acc", 32'(n_acc), 32'd16);
    check("t3_ptr", 32'(read_ptr), 32'b11000);
    check("t3_addr", 32'(read_addr), 32'd0);
    check("t3_count", 32'(read_count), 32'd0);

    // 4. Backpressure: ready toggles every cycle.
    n_acc = 0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h30 + i));
    drain(1'b1, 100, "t4_drain");
    out_if.out_ready = 1'b1;
    check("t4_acc", 32'(n_acc), 32'd8);

    // 5. Pointer wrap: 40 words in chunks of 16, 16 and 8.
    gray_en = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 16; k++) push_word(8'(8'h80 + k));
    drain(1'b0, 60, "t5_drain_a");
    for (int k = 16; k < 32; k++) push_word(8'(8'h80 + k));
    drain(1'b0, 60, "t5_drain_b");
    for (int k = 32; k < 40; k++) push_word(8'(8'h80 + k));
    drain(1'b0, 60, "t5_drain_c");
    @(negedge read_clock);
    gray_en = 1'b0;
    check("t5_acc", 32'(n_acc), 32'd40);
    check("t5_empty", 32'(read_empty), 32'd1);
    check("t5_ptr", 32'(read_ptr), 32'(bin2gray(wr_bin)));

    // 6. Reset while a word is held and 5 entries are pending.
    step();
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'(8'h50 + i));
    repeat (4) step();
    @(negedge read_clock);
    check("t6_valid_pre", 32'(out_if.out_valid), 32'd1);
    check("t6_count_pre", 32'(read_count), 32'd5);
    check("t6_data_pre", 32'(out_if.out_data), 32'h50);
    step();
    do_reset();
    @(negedge read_clock);
    check("t6_rst_valid", 32'(out_if.out_valid), 32'd0);
    check("t6_rst_empty", 32'(read_empty), 32'd1);
    check("t6_rst_ptr", 32'(read_ptr), 32'd0);
    check("t6_rst_count", 32'(read_count), 32'd0);
    check("t6_rst_data", 32'(out_if.out_data), 32'd0);
    step();
    n_acc = 0;
    out_if.out_ready = 1'b1;
    repeat (8) step();
    @(negedge read_clock);
    check("t6_no_beat", 32'(n_acc), 32'd0);
    check("t6_end_empty", 32'(read_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
